uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param_if.sv | 12 +
 rtl/uart_rx_param.sv | 115 +++++++++++
 tb/tb_uart_rx_param.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: serial line, enable and received-frame result signals of uart_rx_param
interface uart_rx_param_if #(parameter int PAYLOAD_BITS = 8);
  logic uart_rxd;
  logic recv_en;
  logic recv_valid;
  logic [PAYLOAD_BITS-1:0] recv_data;
  logic frame_err;
  logic parity_err;
  logic recv_break;
  modport master (input uart_rxd, recv_en, output recv_valid, recv_data, frame_err, parity_err, recv_break);
  modport slave (output uart_rxd, recv_en, input recv_valid, recv_data, frame_err, parity_err, recv_break);
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver (5..8 data bits, 1/2 stop bits)
// Parity checking is built only when UART_RX_PARITY_EN is defined; otherwise PARITY is ignored.
module uart_rx_param #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 100000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input logic clk,
  input logic resetn,
  uart_rx_param_if.master bus
);
  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT = CYCLES_PER_BIT / 2;
  localparam int CW = $clog2(CYCLES_PER_BIT) + 1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = PARITY != 0;
  localparam bit ODD = PARITY == 2;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY < 0 || PARITY > 2) begin : g_bad_cfg
    $error("uart_rx_param: illegal parameter combination");
  end
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic [1:0] sync;
  logic armed;
  logic stop_bad;
  logic rxd, tick, half, last_data, last_stop, ferr;
  assign rxd = sync[1];
  assign tick = cnt == CW'(CYCLES_PER_BIT - 1);
  assign half = cnt == CW'(HALF_BIT - 1);
  assign last_data = idx == 4'(PAYLOAD_BITS - 1);
  assign last_stop = idx == 4'(STOP_BITS - 1);
  assign ferr = stop_bad | ~rxd;
`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign bus.parity_err = 1'b0;
`endif
  // armed blocks a restart while the line is still low after a break frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      idx            <= '0;
      shreg          <= '0;
      sync           <= 2'b11;
      armed          <= 1'b0;
      stop_bad       <= 1'b0;
      bus.recv_valid <= 1'b0;
      bus.recv_data  <= '0;
      bus.frame_err  <= 1'b0;
      bus.recv_break <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad        <= 1'b0;
      bus.parity_err <= 1'b0;
`endif
    end else begin
      sync           <= {sync[0], bus.uart_rxd};
      bus.recv_valid <= 1'b0;
      if (rxd) armed <= 1'b1;
      case (state)
        ST_IDLE: if (!rxd && bus.recv_en && armed) begin
          state    <= ST_START;
          cnt      <= '0;
          idx      <= '0;
          stop_bad <= 1'b0;
          armed    <= 1'b0;
`ifdef UART_RX_PARITY_EN
          par_bad  <= 1'b0;
`endif
        end
        ST_START: if (half) begin
          state <= rxd ? ST_IDLE : ST_DATA;
          cnt   <= '0;
        end else cnt <= cnt + CW'(1);
        ST_DATA: if (tick) begin
          cnt   <= '0;
          shreg <= {rxd, shreg[PAYLOAD_BITS-1:1]};
          idx   <= last_data ? 4'd0 : idx + 4'd1;
          if (last_data) state <= PAR_ON ? ST_PARITY : ST_STOP;
        end else cnt <= cnt + CW'(1);
`ifdef UART_RX_PARITY_EN
        ST_PARITY: if (tick) begin
          cnt     <= '0;
          par_bad <= rxd ^ (^shreg) ^ ODD;
          state   <= ST_STOP;
        end else cnt <= cnt + CW'(1);
`endif
        ST_STOP: if (tick) begin
          cnt      <= '0;
          idx      <= last_stop ? 4'd0 : idx + 4'd1;
          stop_bad <= ferr;
          if (last_stop) begin
            state          <= ST_IDLE;
            bus.recv_valid <= 1'b1;
            bus.recv_data  <= shreg;
            bus.frame_err  <= ferr;
            bus.recv_break <= ferr && (shreg == '0);
`ifdef UART_RX_PARITY_EN
            bus.parity_err <= par_bad;
`endif
          end
        end else cnt <= cnt + CW'(1);
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of uart_rx_param at 10 clocks per bit (8N1, 7N2 and 8E1 instances)
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en = 1'b1;
  logic [2:0] rxd = 3'b111;
  int errs = 0;
  int checks = 0;
  int n0 = 0, n2 = 0;
  logic [7:0] d0 = 8'h00, d2 = 8'h00;
  logic fe0 = 1'b0, pe0 = 1'b0, br0 = 1'b0, fe2 = 1'b0, pe2 = 1'b0;
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  uart_rx_param_if #(.PAYLOAD_BITS(8)) i0 ();
  uart_rx_param_if #(.PAYLOAD_BITS(7)) i1 ();
  uart_rx_param_if #(.PAYLOAD_BITS(8)) i2 ();
  assign i0.uart_rxd = rxd[0];
  assign i1.uart_rxd = rxd[1];
  assign i2.uart_rxd = rxd[2];
  assign i0.recv_en = en;
  assign i1.recv_en = en;
  assign i2.recv_en = en;

  uart_rx_param #(.BIT_RATE(100000), .CLK_HZ(1000000), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY(0))
    d_8n1 (.clk(clk), .resetn(resetn), .bus(i0));
  uart_rx_param #(.BIT_RATE(100000), .CLK_HZ(1000000), .PAYLOAD_BITS(7), .STOP_BITS(2), .PARITY(0))
    d_7n2 (.clk(clk), .resetn(resetn), .bus(i1));
  uart_rx_param #(.BIT_RATE(100000), .CLK_HZ(1000000), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY(1))
    d_8e1 (.clk(clk), .resetn(resetn), .bus(i2));

  always @(negedge clk) if (i0.recv_valid === 1'b1) begin
    n0 <= n0 + 1; d0 <= i0.recv_data; fe0 <= i0.frame_err; pe0 <= i0.parity_err; br0 <= i0.recv_break;
  end
  always @(negedge clk) if (i1.recv_valid === 1'b1) q1.push_back({1'b0, i1.recv_data});
  always @(negedge clk) if (i2.recv_valid === 1'b1) begin
    n2 <= n2 + 1; d2 <= i2.recv_data; fe2 <= i2.frame_err; pe2 <= i2.parity_err;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // frame bits are driven LSB first, each held for one bit time
  task automatic send(input int k, input logic [11:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rxd[k] = f[i];
      repeat (10) @(negedge clk);
    end
    rxd[k] = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    idle(3);
    checks++; if (i0.recv_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", i0.recv_valid); end
    checks++; if (i0.recv_data !== 8'h00) begin errs++; $display("FAIL reset_data got=%h exp=00", i0.recv_data); end
    checks++; if (i0.frame_err !== 1'b0) begin errs++; $display("FAIL reset_frame_err got=%b exp=0", i0.frame_err); end
    checks++; if (i0.parity_err !== 1'b0) begin errs++; $display("FAIL reset_parity_err got=%b exp=0", i0.parity_err); end
    checks++; if (i0.recv_break !== 1'b0) begin errs++; $display("FAIL reset_break got=%b exp=0", i0.recv_break); end
    @(negedge clk);
    resetn = 1'b1;
    idle(10);
    checks++; if (n0 !== 0) begin errs++; $display("FAIL reset_no_valid got=%0d exp=0", n0); end
  endtask

  task automatic test_8n1;
    logic [7:0] tbl [3] = '{8'h55, 8'hA3, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      int base = n0;
      send(0, {3'b111, tbl[i], 1'b0}, 10);
      idle(20);
      checks++; if (n0 !== base + 1) begin errs++; $display("FAIL 8n1_count[%0d] got=%0d exp=%0d", i, n0, base + 1); end
      checks++; if (d0 !== tbl[i]) begin errs++; $display("FAIL 8n1_data[%0d] got=%h exp=%h", i, d0, tbl[i]); end
      checks++; if (fe0 !== 1'b0) begin errs++; $display("FAIL 8n1_frame_err[%0d] got=%b exp=0", i, fe0); end
      checks++; if (pe0 !== 1'b0) begin errs++; $display("FAIL 8n1_parity_err[%0d] got=%b exp=0", i, pe0); end
      checks++; if (br0 !== 1'b0) begin errs++; $display("FAIL 8n1_break[%0d] got=%b exp=0", i, br0); end
    end
  endtask

  // 0xA7 has five ones, so the even-parity bit is 1
  task automatic test_parity;
    int base = n2;
    send(2, {2'b11, 1'b0, 8'hA7, 1'b0}, 11);
    idle(20);
    checks++; if (n2 !== base + 1) begin errs++; $display("FAIL par_bad_count got=%0d exp=%0d", n2, base + 1); end
    checks++; if (d2 !== 8'hA7) begin errs++; $display("FAIL par_bad_data got=%h exp=a7", d2); end
`ifdef UART_RX_PARITY_EN
    checks++; if (pe2 !== 1'b1) begin errs++; $display("FAIL par_bad_parity_err got=%b exp=1", pe2); end
    checks++; if (fe2 !== 1'b0) begin errs++; $display("FAIL par_bad_frame_err got=%b exp=0", fe2); end
`else
    checks++; if (pe2 !== 1'b0) begin errs++; $display("FAIL par_bad_parity_err got=%b exp=0", pe2); end
    checks++; if (fe2 !== 1'b1) begin errs++; $display("FAIL par_bad_frame_err got=%b exp=1", fe2); end
`endif
    send(2, {2'b11, 1'b1, 8'hA7, 1'b0}, 11);
    idle(20);
    checks++; if (n2 !== base + 2) begin errs++; $display("FAIL par_ok_count got=%0d exp=%0d", n2, base + 2); end
    checks++; if (d2 !== 8'hA7) begin errs++; $display("FAIL par_ok_data got=%h exp=a7", d2); end
    checks++; if (pe2 !== 1'b0) begin errs++; $display("FAIL par_ok_parity_err got=%b exp=0", pe2); end
    checks++; if (fe2 !== 1'b0) begin errs++; $display("FAIL par_ok_frame_err got=%b exp=0", fe2); end
  endtask

  task automatic test_glitch;
    int base = n0;
    rxd[0] = 1'b0;
    repeat (3) @(negedge clk);
    rxd[0] = 1'b1;
    idle(30);
    checks++; if (n0 !== base) begin errs++; $display("FAIL glitch_count got=%0d exp=%0d", n0, base); end
    send(0, {3'b111, 8'h3C, 1'b0}, 10);
    idle(20);
    checks++; if (n0 !== base + 1) begin errs++; $display("FAIL glitch_next_count got=%0d exp=%0d", n0, base + 1); end
    checks++; if (d0 !== 8'h3C) begin errs++; $display("FAIL glitch_next_data got=%h exp=3c", d0); end
    checks++; if (fe0 !== 1'b0) begin errs++; $display("FAIL glitch_next_frame_err got=%b exp=0", fe0); end
  endtask

  task automatic test_break;
    int base = n0;
    rxd[0] = 1'b0;
    repeat (120) @(negedge clk);
    #2;
    checks++; if (n0 !== base + 1) begin errs++; $display("FAIL break_count got=%0d exp=%0d", n0, base + 1); end
    checks++; if (d0 !== 8'h00) begin errs++; $display("FAIL break_data got=%h exp=00", d0); end
    checks++; if (fe0 !== 1'b1) begin errs++; $display("FAIL break_frame_err got=%b exp=1", fe0); end
    checks++; if (br0 !== 1'b1) begin errs++; $display("FAIL break_flag got=%b exp=1", br0); end
    idle(60);
    checks++; if (n0 !== base + 1) begin errs++; $display("FAIL break_held_low got=%0d exp=%0d", n0, base + 1); end
    rxd[0] = 1'b1;
    idle(30);
    checks++; if (n0 !== base + 1) begin errs++; $display("FAIL break_release got=%0d exp=%0d", n0, base + 1); end
    send(0, {3'b111, 8'h55, 1'b0}, 10);
    idle(20);
    checks++; if (d0 !== 8'h55 || br0 !== 1'b0) begin errs++; $display("FAIL break_recover got=%h/%b exp=55/0", d0, br0); end
  endtask

  task automatic test_back_to_back;
    q1.delete();
    send(1, {2'b11, 2'b11, 7'h01, 1'b0}, 10);
    send(1, {2'b11, 2'b11, 7'h7E, 1'b0}, 10);
    idle(20);
    checks++; if (q1.size() !== 2) begin errs++; $display("FAIL b2b_count got=%0d exp=2", q1.size()); end
    checks++; if ((q1.size() > 0 ? q1[0] : 8'hEE) !== 8'h01) begin errs++; $display("FAIL b2b_first got=%h exp=01", q1.size() > 0 ? q1[0] : 8'hEE); end
    checks++; if ((q1.size() > 1 ? q1[1] : 8'hEE) !== 8'h7E) begin errs++; $display("FAIL b2b_second got=%h exp=7e", q1.size() > 1 ? q1[1] : 8'hEE); end
  endtask

  task automatic test_recv_en;
    int base = n0;
    fork
      send(0, {3'b111, 8'h96, 1'b0}, 10);
      begin repeat (30) @(negedge clk); en = 1'b0; end
    join
    idle(20);
    checks++; if (n0 !== base + 1) begin errs++; $display("FAIL en_midframe_count got=%0d exp=%0d", n0, base + 1); end
    checks++; if (d0 !== 8'h96) begin errs++; $display("FAIL en_midframe_data got=%h exp=96", d0); end
    send(0, {3'b111, 8'h5A, 1'b0}, 10);
    idle(20);
    checks++; if (n0 !== base + 1) begin errs++; $display("FAIL en_low_ignored got=%0d exp=%0d", n0, base + 1); end
    en = 1'b1;
    idle(10);
  endtask

  task automatic test_reset_midframe;
    int base = n0;
    send(0, {3'b111, 8'h81, 1'b0}, 5);
    rxd[0] = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    idle(3);
    checks++; if (i0.recv_data !== 8'h00) begin errs++; $display("FAIL midreset_data got=%h exp=00", i0.recv_data); end
    checks++; if (i0.frame_err !== 1'b0 || i0.recv_break !== 1'b0) begin errs++; $display("FAIL midreset_flags got=%b%b exp=00", i0.frame_err, i0.recv_break); end
    @(negedge clk);
    resetn = 1'b1;
    rxd[0] = 1'b1;
    idle(60);
    checks++; if (n0 !== base) begin errs++; $display("FAIL midreset_no_valid got=%0d exp=%0d", n0, base); end
    send(0, {3'b111, 8'h81, 1'b0}, 10);
    idle(20);
    checks++; if (n0 !== base + 1) begin errs++; $display("FAIL midreset_next_count got=%0d exp=%0d", n0, base + 1); end
    checks++; if (d0 !== 8'h81) begin errs++; $display("FAIL midreset_next_data got=%h exp=81", d0); end
    checks++; if (fe0 !== 1'b0) begin errs++; $display("FAIL midreset_next_frame_err got=%b exp=0", fe0); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_back_to_back();
    test_recv_en();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
